axi_beat_splitter: RTL
======================

AXI_BEAT_SPLITTER -- requirements
Module: axi_beat_splitter

Interface
REQ-001 Parameter TAGW, 1, AXI ID width on both sides.
REQ-002 Parameter ADDRW, 32, address width.
REQ-003 aclk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_l  input  1  reset; asynchronous assert, active-low.
REQ-005 s_ar{valid,ready,addr,id,len,burst,size}  in/out/in...  1/1/ADDRW/TAGW/8/2/3  upstream AXI4 read address.
REQ-006 s_r{valid,ready,data,resp,id,last}  out/in/out...  1/1/64/2/TAGW/1  upstream read data.
REQ-007 s_aw{valid,ready,addr,id,len,burst,size}  same widths as AR  upstream write address.
REQ-008 s_w{valid,ready,data,strb,last}  in/out/in/in/in  1/1/64/8/1  upstream write data.
REQ-009 s_b{valid,ready,resp,id}  out/in/out/out  1/1/2/TAGW  upstream write response.
REQ-010 m_* AR/R/AW/W/B ports  mirror of s_* with sources swapped  downstream single-beat slave; m_arlen=m_awlen=0, m_arburst=m_awburst=2'b01, m_wlast=1 constant.

Function
REQ-011 Read and write paths SHALL be independent FSMs and SHALL operate concurrently.
REQ-012 Read FSM states R_IDLE, R_ISSUE, R_WAIT; s_arready=1 only in R_IDLE.
REQ-013 R_IDLE: on s_arvalid latch addr/id/len/size/burst, clear beat count, go R_ISSUE next cycle.
REQ-014 R_ISSUE: m_arvalid=1 with current addr, size, latched id; on m_arready go R_WAIT.
REQ-015 R_WAIT: m_rready=s_rready; s_rvalid=m_rvalid; s_rdata/s_rresp forwarded combinationally; s_rid=latched id; s_rlast=(beat count==len); m_rlast ignored.
REQ-016 On R handshake: if last go R_IDLE, else advance address, increment count, go R_ISSUE.
REQ-017 Write FSM states W_IDLE, W_DATA, W_WAIT, W_RESP; s_awready=1 only in W_IDLE.
REQ-018 W_DATA: m_awvalid=m_wvalid=s_wvalid (always coincident); s_wready=m_awready&&m_wready; on transfer go W_WAIT.
REQ-019 W_WAIT: m_bready=1; on m_bvalid merge resp as numeric max (OKAY<EXOKAY<SLVERR<DECERR); last beat -> W_RESP, else advance address -> W_DATA.
REQ-020 s_wlast mismatch (asserted at count!=len or deasserted at count==len) SHALL force merged resp to SLVERR; beat count, not wlast, ends burst.
REQ-021 W_RESP: s_bvalid=1, s_bid=latched id, s_bresp=merged resp, held stable until s_bready; then W_IDLE, merged resp cleared to OKAY.
REQ-022 Address advance: FIXED keeps addr; INCR adds 1<<size modulo 2^ADDRW (wraps past 0xFFFFFFFF to 0); burst 2'b11 treated as INCR.
REQ-023 len=0 SHALL produce exactly one downstream beat; len=255 exactly 256.
REQ-024 Beat counters 8 bits; no state other than FSM registers, counters, latched AR/AW fields, merged resp.
REQ-025 Latency: first m_arvalid/m_awvalid-eligible cycle is one cycle after s_ar/s_aw handshake.

Reset
REQ-026 rst_l low SHALL immediately force R_IDLE, W_IDLE, counters 0, merged resp OKAY.
REQ-027 During reset all valid/ready outputs SHALL be 0, including s_arready/s_awready.
REQ-028 Reset mid-burst SHALL abandon the burst with no further downstream or upstream beats.

Configuration
REQ-029 Macro RV_AXI_SPLIT_WRAP_EN: defined -> WRAP (2'b10) wraps address within aligned (len+1)<<size window; undefined -> WRAP treated as INCR and merged/read resp forced SLVERR on every beat.

Structure
REQ-030 Package axi_split_pkg SHALL hold burst encodings, resp codes, and both FSM state enums.
REQ-031 Sub-module axi_split_addr_gen SHALL compute next address from addr, size, len, burst; instantiated once per path.

Verification
REQ-032 AR addr=0x1000 len=3 size=3 INCR -> 4 m_ar at 0x1000,0x1008,0x1010,0x1018; s_rlast only on 4th beat.
REQ-033 AW addr=0x2000 len=1 INCR, W beats strb=0xFF, wlast on 2nd -> 2 coincident m_aw/m_w, one s_b resp=OKAY id echoed.
REQ-034 Write len=2 with second beat m_bresp=SLVERR -> single s_bresp=SLVERR after third beat.
REQ-035 AR addr=0xFFFFFFF8 len=1 size=3 INCR -> second m_araddr=0x00000000.
REQ-036 With RV_AXI_SPLIT_WRAP_EN: AR addr=0x1018 len=3 size=3 WRAP -> 0x1018,0x1000,0x1008,0x1010; without macro -> INCR sequence, all rresp=SLVERR.
REQ-037 rst_l low during beat 2 of 4-beat read with s_rready stalled -> all valids 0 immediately; after release s_arready=1, no stale beats.

Source files
------------

// File: rtl/axi_split_pkg.sv
// rtl/axi_split_pkg.sv - burst/resp encodings and FSM state types for axi_beat_splitter
package axi_split_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_t;

  // Severity order matches the numeric encoding, so merging is a plain max.
  function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_split_addr_gen.sv
// rtl/axi_split_addr_gen.sv - next beat address for FIXED/INCR/WRAP bursts
// WRAP handling is present only when RV_AXI_SPLIT_WRAP_EN is defined; otherwise WRAP advances as INCR.
module axi_split_addr_gen
  import axi_split_pkg::*;
#(
  parameter int ADDRW = 32
) (
  input  logic [ADDRW-1:0] addr,
  input  logic [2:0]       size,
  input  logic [7:0]       len,
  input  logic [1:0]       burst,
  output logic [ADDRW-1:0] next_addr
);

  logic [ADDRW-1:0] step;
  logic [ADDRW-1:0] incr_addr;

  assign step      = ADDRW'(1) << size;
  assign incr_addr = addr + step;

`ifdef RV_AXI_SPLIT_WRAP_EN
  logic [ADDRW-1:0] wrap_mask;

  // Window is (len+1)<<size bytes and aligned to its own size.
  assign wrap_mask = ((ADDRW'(len) + ADDRW'(1)) << size) - ADDRW'(1);

  always_comb begin
    next_addr = incr_addr;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end
`else
  logic unused_len;
  assign unused_len = ^len;

  always_comb begin
    next_addr = incr_addr;
    if (burst == BURST_FIXED) next_addr = addr;
  end
`endif

endmodule

// File: rtl/axi_beat_splitter.sv
// rtl/axi_beat_splitter.sv - splits AXI4 read/write bursts into single-beat downstream transfers
// Define RV_AXI_SPLIT_WRAP_EN to support WRAP bursts; without it WRAP beats answer SLVERR.
module axi_beat_splitter
  import axi_split_pkg::*;
#(
  parameter int TAGW  = 1,
  parameter int ADDRW = 32
) (
  input  logic             aclk,
  input  logic             rst_l,
  input  logic             s_arvalid,
  output logic             s_arready,
  input  logic [ADDRW-1:0] s_araddr,
  input  logic [TAGW-1:0]  s_arid,
  input  logic [7:0]       s_arlen,
  input  logic [1:0]       s_arburst,
  input  logic [2:0]       s_arsize,
  output logic             s_rvalid,
  input  logic             s_rready,
  output logic [63:0]      s_rdata,
  output logic [1:0]       s_rresp,
  output logic [TAGW-1:0]  s_rid,
  output logic             s_rlast,
  input  logic             s_awvalid,
  output logic             s_awready,
  input  logic [ADDRW-1:0] s_awaddr,
  input  logic [TAGW-1:0]  s_awid,
  input  logic [7:0]       s_awlen,
  input  logic [1:0]       s_awburst,
  input  logic [2:0]       s_awsize,
  input  logic             s_wvalid,
  output logic             s_wready,
  input  logic [63:0]      s_wdata,
  input  logic [7:0]       s_wstrb,
  input  logic             s_wlast,
  output logic             s_bvalid,
  input  logic             s_bready,
  output logic [1:0]       s_bresp,
  output logic [TAGW-1:0]  s_bid,
  output logic             m_arvalid,
  input  logic             m_arready,
  output logic [ADDRW-1:0] m_araddr,
  output logic [TAGW-1:0]  m_arid,
  output logic [7:0]       m_arlen,
  output logic [1:0]       m_arburst,
  output logic [2:0]       m_arsize,
  input  logic             m_rvalid,
  output logic             m_rready,
  input  logic [63:0]      m_rdata,
  input  logic [1:0]       m_rresp,
  input  logic [TAGW-1:0]  m_rid,
  input  logic             m_rlast,
  output logic             m_awvalid,
  input  logic             m_awready,
  output logic [ADDRW-1:0] m_awaddr,
  output logic [TAGW-1:0]  m_awid,
  output logic [7:0]       m_awlen,
  output logic [1:0]       m_awburst,
  output logic [2:0]       m_awsize,
  output logic             m_wvalid,
  input  logic             m_wready,
  output logic [63:0]      m_wdata,
  output logic [7:0]       m_wstrb,
  output logic             m_wlast,
  input  logic             m_bvalid,
  output logic             m_bready,
  input  logic [1:0]       m_bresp,
  input  logic [TAGW-1:0]  m_bid
);

`ifdef RV_AXI_SPLIT_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic unused_inputs;
  assign unused_inputs = ^{m_rid, m_rlast, m_bid};

  r_state_t         r_state;
  logic [ADDRW-1:0] r_addr, r_next_addr;
  logic [TAGW-1:0]  r_id;
  logic [7:0]       r_len, r_cnt;
  logic [2:0]       r_size;
  logic [1:0]       r_burst;
  logic             r_last, r_hs, r_wrap_err;

  axi_split_addr_gen #(.ADDRW(ADDRW)) u_r_addr_gen (
    .addr      (r_addr),
    .size      (r_size),
    .len       (r_len),
    .burst     (r_burst),
    .next_addr (r_next_addr)
  );

  // Ready is also gated by reset so it stays low while rst_l is held.
  assign s_arready  = rst_l && (r_state == R_IDLE);
  assign m_arvalid  = (r_state == R_ISSUE);
  assign m_araddr   = r_addr;
  assign m_arid     = r_id;
  assign m_arsize   = r_size;
  assign m_arlen    = 8'd0;
  assign m_arburst  = BURST_INCR;
  assign r_last     = (r_cnt == r_len);
  assign r_wrap_err = !WRAP_EN && (r_burst == BURST_WRAP);
  assign s_rvalid   = (r_state == R_WAIT) && m_rvalid;
  assign m_rready   = (r_state == R_WAIT) && s_rready;
  assign s_rdata    = m_rdata;
  assign s_rresp    = r_wrap_err ? RESP_SLVERR : m_rresp;
  assign s_rid      = r_id;
  assign s_rlast    = r_last;
  assign r_hs       = s_rvalid && s_rready;

  always_ff @(posedge aclk or negedge rst_l) begin
    if (!rst_l) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_id    <= '0;
      r_len   <= 8'd0;
      r_cnt   <= 8'd0;
      r_size  <= 3'd0;
      r_burst <= BURST_FIXED;
    end else begin
      case (r_state)
        R_IDLE: if (s_arvalid) begin
          r_addr  <= s_araddr;
          r_id    <= s_arid;
          r_len   <= s_arlen;
          r_size  <= s_arsize;
          r_burst <= s_arburst;
          r_cnt   <= 8'd0;
          r_state <= R_ISSUE;
        end
        R_ISSUE: if (m_arready) r_state <= R_WAIT;
        R_WAIT: if (r_hs) begin
          if (r_last) begin
            r_state <= R_IDLE;
          end else begin
            r_addr  <= r_next_addr;
            r_cnt   <= r_cnt + 8'd1;
            r_state <= R_ISSUE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  w_state_t         w_state;
  logic [ADDRW-1:0] w_addr, w_next_addr;
  logic [TAGW-1:0]  w_id;
  logic [7:0]       w_len, w_cnt;
  logic [2:0]       w_size;
  logic [1:0]       w_burst, w_resp;
  logic             w_last, w_hs, w_wrap_err;

  axi_split_addr_gen #(.ADDRW(ADDRW)) u_w_addr_gen (
    .addr      (w_addr),
    .size      (w_size),
    .len       (w_len),
    .burst     (w_burst),
    .next_addr (w_next_addr)
  );

  assign s_awready  = rst_l && (w_state == W_IDLE);
  assign m_awvalid  = (w_state == W_DATA) && s_wvalid;
  assign m_wvalid   = (w_state == W_DATA) && s_wvalid;
  assign s_wready   = (w_state == W_DATA) && m_awready && m_wready;
  assign m_awaddr   = w_addr;
  assign m_awid     = w_id;
  assign m_awsize   = w_size;
  assign m_awlen    = 8'd0;
  assign m_awburst  = BURST_INCR;
  assign m_wdata    = s_wdata;
  assign m_wstrb    = s_wstrb;
  assign m_wlast    = 1'b1;
  assign m_bready   = (w_state == W_WAIT);
  assign s_bvalid   = (w_state == W_RESP);
  assign s_bresp    = w_resp;
  assign s_bid      = w_id;
  assign w_last     = (w_cnt == w_len);
  assign w_wrap_err = !WRAP_EN && (w_burst == BURST_WRAP);
  assign w_hs       = s_wvalid && s_wready;

  always_ff @(posedge aclk or negedge rst_l) begin
    if (!rst_l) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_id    <= '0;
      w_len   <= 8'd0;
      w_cnt   <= 8'd0;
      w_size  <= 3'd0;
      w_burst <= BURST_FIXED;
      w_resp  <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: if (s_awvalid) begin
          w_addr  <= s_awaddr;
          w_id    <= s_awid;
          w_len   <= s_awlen;
          w_size  <= s_awsize;
          w_burst <= s_awburst;
          w_cnt   <= 8'd0;
          w_state <= W_DATA;
        end
        W_DATA: if (w_hs) begin
          // The beat count ends the burst; a misplaced wlast only taints the response.
          if ((s_wlast != w_last) || w_wrap_err) w_resp <= resp_merge(w_resp, RESP_SLVERR);
          w_state <= W_WAIT;
        end
        W_WAIT: if (m_bvalid) begin
          w_resp <= resp_merge(w_resp, m_bresp);
          if (w_last) begin
            w_state <= W_RESP;
          end else begin
            w_addr  <= w_next_addr;
            w_cnt   <= w_cnt + 8'd1;
            w_state <= W_DATA;
          end
        end
        W_RESP: if (s_bready) begin
          w_resp  <= RESP_OKAY;
          w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule
